fighter_remote_link: RTL

- Player-2 side of the fighter UART link; runs on the remote board, opposite the game master.
- Answers the master's HELLO with the ACK byte 0xA5 and then streams the local player's action byte.
- Parses the master's 5-byte state packets and presents game state and both HP values to local display logic.
- Sits between the local UART rx/tx byte interfaces and local controls/HUD.

---
 rtl/fighter_remote_link.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/fighter_remote_link.sv
`timescale 1ns/1ps
// Player-2 end of the fighter UART link: HELLO/ACK handshake, periodic action bytes,
// and the 5-byte state-packet parser. Optional build macro: ACTION_ON_CHANGE_EN.
module fighter_remote_link #(
  parameter int unsigned ACTION_PERIOD = 1000,
  parameter int unsigned LINK_TIMEOUT  = 50000,
  parameter logic [7:0]  HELLO_BYTE    = 8'h5A,
  parameter logic [7:0]  ACK_BYTE      = 8'hA5,
  parameter logic [7:0]  PKT_HDR       = 8'hC3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  input  logic [2:0] p2_ctrl,
  output logic       link_up,
  output logic [2:0] game_state,
  output logic [7:0] p1_hp,
  output logic [7:0] p2_hp,
  output logic       pkt_valid,
  output logic       chk_err
);

  localparam int unsigned PER_W = (ACTION_PERIOD > 1) ? $clog2(ACTION_PERIOD) : 1;
  localparam int unsigned TO_W  = $clog2(LINK_TIMEOUT + 1);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(ACTION_PERIOD - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LINK_TIMEOUT - 1);

  typedef enum logic [1:0] {UNLINKED, ACK_PEND, LINKED} link_state_e;
  typedef enum logic [2:0] {P_HDR, P_ST, P_H1, P_H2, P_CHK} parse_state_e;

  typedef struct packed {
    logic [7:0] st;
    logic [7:0] h1;
    logic [7:0] h2;
  } pkt_fields_t;

  link_state_e      link_state, link_next;
  parse_state_e     parse_state, parse_next;
  pkt_fields_t      fields;
  logic             start_req;
  logic             action_pend;
  logic [PER_W-1:0] per_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic [7:0]       action_c;
  logic             hello_c, wrap_c, timeout_c, enter_c, change_c;
  logic             ack_send_c, act_send_c;
  logic             chk_ok_c, pkt_ok_c, pkt_bad_c;

  // Attack outranks block when both are pressed.
  always_comb begin
    action_c = 8'h00;
    if (p2_ctrl[1])      action_c = 8'h20;
    else if (p2_ctrl[0]) action_c = 8'h10;
  end

  assign hello_c   = rx_valid && (rx_data == HELLO_BYTE);
  assign wrap_c    = (link_state == LINKED) && (per_cnt == PER_LAST);
  assign timeout_c = (link_state == LINKED) && !pkt_valid && (to_cnt == TO_LAST);
  assign enter_c   = (link_state != LINKED) && (link_next == LINKED);

`ifdef ACTION_ON_CHANGE_EN
  logic [7:0] last_sent;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          last_sent <= 8'h00;
    else if (act_send_c) last_sent <= action_c;
  end

  assign change_c = (link_state == LINKED) && (action_c != last_sent);
`else
  assign change_c = 1'b0;
`endif

  // Link FSM: state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) link_state <= UNLINKED;
    else        link_state <= link_next;
  end

  // Link FSM: ACK_PEND stays put until its own ACK pulse is on the wire.
  always_comb begin
    link_next = link_state;
    case (link_state)
      UNLINKED: if (hello_c && start_req) link_next = ACK_PEND;
      ACK_PEND: if (tx_start)             link_next = LINKED;
      LINKED:   if (timeout_c)            link_next = UNLINKED;
      default:                            link_next = UNLINKED;
    endcase
  end

  // Link FSM: transmit decisions; never back-to-back and never into a busy UART.
  always_comb begin
    ack_send_c = 1'b0;
    act_send_c = 1'b0;
    case (link_state)
      ACK_PEND: ack_send_c = !tx_busy && !tx_start;
      LINKED:   act_send_c = action_pend && !tx_busy && !tx_start;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_start    <= 1'b0;
      tx_data     <= 8'h00;
      link_up     <= 1'b0;
      start_req   <= 1'b0;
      action_pend <= 1'b0;
      per_cnt     <= '0;
      to_cnt      <= '0;
    end else begin
      tx_start <= ack_send_c || act_send_c;
      if (ack_send_c)      tx_data <= ACK_BYTE;
      else if (act_send_c) tx_data <= action_c;
      link_up <= (link_next == LINKED);

      if (enter_c || timeout_c) start_req <= 1'b0;
      else if (p2_ctrl[2])      start_req <= 1'b1;

      // A wrap while a byte is still pending does not queue a second one.
      if ((link_state != LINKED) || (link_next != LINKED)) begin
        per_cnt     <= '0;
        action_pend <= 1'b0;
      end else begin
        per_cnt <= wrap_c ? '0 : per_cnt + PER_W'(1);
        if (act_send_c)               action_pend <= 1'b0;
        else if (wrap_c || change_c)  action_pend <= 1'b1;
      end

      if ((link_state != LINKED) || pkt_valid) to_cnt <= '0;
      else                                     to_cnt <= to_cnt + TO_W'(1);
    end
  end

  // Parser FSM: state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parse_state <= P_HDR;
    else        parse_state <= parse_next;
  end

  // Parser FSM: a header-valued byte mid-packet is plain data (no resync).
  always_comb begin
    parse_next = parse_state;
    if (rx_valid) begin
      case (parse_state)
        P_HDR:   if (rx_data == PKT_HDR) parse_next = P_ST;
        P_ST:    parse_next = P_H1;
        P_H1:    parse_next = P_H2;
        P_H2:    parse_next = P_CHK;
        P_CHK:   parse_next = P_HDR;
        default: parse_next = P_HDR;
      endcase
    end
  end

  // Parser FSM: checksum verdict on the final byte.
  always_comb begin
    chk_ok_c  = (rx_data == (fields.st ^ fields.h1 ^ fields.h2));
    pkt_ok_c  = 1'b0;
    pkt_bad_c = 1'b0;
    if (rx_valid && (parse_state == P_CHK)) begin
      pkt_ok_c  = chk_ok_c;
      pkt_bad_c = !chk_ok_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fields     <= '0;
      game_state <= 3'd0;
      p1_hp      <= 8'd100;
      p2_hp      <= 8'd100;
      pkt_valid  <= 1'b0;
      chk_err    <= 1'b0;
    end else begin
      pkt_valid <= pkt_ok_c;
      chk_err   <= pkt_bad_c;
      if (rx_valid) begin
        case (parse_state)
          P_ST:    fields.st <= rx_data;
          P_H1:    fields.h1 <= rx_data;
          P_H2:    fields.h2 <= rx_data;
          default: ;
        endcase
      end
      if (pkt_ok_c) begin
        game_state <= fields.st[2:0];
        p1_hp      <= fields.h1;
        p2_hp      <= fields.h2;
      end
    end
  end

endmodule
